// File: rtl/sa_test_pkg.sv
// sa_test_pkg: shared types, constants and golden full-adder function for the stuck-at fault tester.
package sa_test_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;
   localparam int NUM_VEC = 8;
   // Returns {carry,sum} for vector {a,b,c}; a is the MSB.
   function automatic logic [1:0] golden_fa(input logic [2:0] vec);
      return {vec[2] & vec[1] | vec[0] & (vec[2] ^ vec[1]), ^vec};
   endfunction
endpackage

// File: rtl/fa_golden.sv
// fa_golden: combinational reference full adder.
//  a, b, c   in  operand bits
//  sum       out a^b^c
//  carry     out majority(a,b,c)
module fa_golden (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b ^ c;
   assign carry = a & b | c & (a ^ b);
endmodule

// File: rtl/sa_fault_tester.sv
// sa_fault_tester: drives all 8 full-adder input vectors into a circuit and checks {F1,F0} against a golden adder.
//  clk, rst_n           clock, async active-low reset
//  start                begin a run (IDLE only)
//  dut_a/b/c            registered vector driven to the circuit (A is MSB)
//  dut_f0/f1            circuit sum/carry, sampled only in SAMPLE
//  busy, done           run in progress / one-cycle end pulse
//  fault_detected       any vector failed
//  fail_mask/count      per-vector failure bits and their count
//  first_fail_vec/obs   lowest failing vector and the {F1,F0} seen there
module sa_fault_tester
   import sa_test_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       dut_a,
   output logic       dut_b,
   output logic       dut_c,
   input  logic       dut_f0,
   input  logic       dut_f1,
   output logic       busy,
   output logic       done,
   output logic       fault_detected,
   output logic [7:0] fail_mask,
   output logic [3:0] fail_count,
   output logic [2:0] first_fail_vec,
   output logic [1:0] first_fail_obs
);
   state_e      state_q, state_d;
   logic [2:0]  vec_q, vec_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [7:0]  mask_q, mask_d;
   logic [3:0]  count_q, count_d;
   logic [2:0]  ffv_q, ffv_d;
   logic [1:0]  ffo_q, ffo_d;
   logic        gold_sum, gold_carry;
   logic        mismatch;

   fa_golden u_gold (
      .a     (vec_q[2]),
      .b     (vec_q[1]),
      .c     (vec_q[0]),
      .sum   (gold_sum),
      .carry (gold_carry)
   );

   assign mismatch = {dut_f1, dut_f0} != {gold_carry, gold_sum};

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      mask_d  = mask_q;
      count_d = count_q;
      ffv_d   = ffv_q;
      ffo_d   = ffo_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = SETTLE;
            vec_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            mask_d  = '0;
            count_d = '0;
            ffv_d   = '0;
            ffo_d   = '0;
         end
         SETTLE: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
         end
         SAMPLE: begin
            if (mismatch) begin
               mask_d[vec_q] = 1'b1;
               count_d       = count_q + 4'd1;
               // count still zero means this is the lowest failing vector
               if (count_q == 4'd0) begin
                  ffv_d = vec_q;
                  ffo_d = {dut_f1, dut_f0};
               end
            end
            if (vec_q == 3'(NUM_VEC - 1)) begin
               state_d = DONE;
               busy_d  = 1'b0;
            end else begin
               state_d = SETTLE;
               vec_d   = vec_q + 3'd1;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         mask_q  <= '0;
         count_q <= '0;
         ffv_q   <= '0;
         ffo_q   <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         mask_q  <= mask_d;
         count_q <= count_d;
         ffv_q   <= ffv_d;
         ffo_q   <= ffo_d;
      end
   end

   assign {dut_a, dut_b, dut_c} = vec_q;
   assign busy           = busy_q;
   assign done           = state_q == DONE;
   assign fault_detected = |mask_q;
   assign fail_mask      = mask_q;
   assign fail_count     = count_q;
   assign first_fail_vec = ffv_q;
   assign first_fail_obs = ffo_q;
endmodule

// File: tb/tb_sa_fault_tester.sv
// tb_sa_fault_tester: scoreboard bench for the stuck-at fault tester with S=1 and S=3 instances.
module tb_sa_fault_tester;
   typedef struct {
      logic [7:0] mask;
      logic [3:0] cnt;
      logic [2:0] ffv;
      logic [1:0] ffo;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0, rst_n = 1'b0, start1 = 1'b0, start3 = 1'b0;
   logic       a1, b1, c1, f0_1, f1_1, busy1, done1, fd1;
   logic       a3, b3, c3, f0_3, f1_3, busy3, done3, fd3;
   logic [7:0] mask1, mask3;
   logic [3:0] cnt1, cnt3;
   logic [2:0] ffv1, ffv3;
   logic [1:0] ffo1, ffo3;
   int         mode1 = 0, mode3 = 0;
   int         total = 0, bad = 0, cyc = 0, done_cnt1 = 0, done_cnt3 = 0;
   exp_t       q1[$], q3[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Circuit under test: 0 fault-free, 1 F1 = C | A&B, 2 F0 stuck-at-0
   function automatic logic [1:0] cut(input int mode, input logic a, input logic b, input logic c);
      logic cy, s;
      cy = a & b | c & (a ^ b);
      s  = a ^ b ^ c;
      if (mode == 1) cy = c | a & b;
      if (mode == 2) s = 1'b0;
      return {cy, s};
   endfunction

   assign {f1_1, f0_1} = cut(mode1, a1, b1, c1);
   assign {f1_3, f0_3} = cut(mode3, a3, b3, c3);

   sa_fault_tester #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_f0(f0_1), .dut_f1(f1_1),
      .busy(busy1), .done(done1), .fault_detected(fd1), .fail_mask(mask1),
      .fail_count(cnt1), .first_fail_vec(ffv1), .first_fail_obs(ffo1)
   );

   sa_fault_tester #(.SETTLE_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3),
      .dut_a(a3), .dut_b(b3), .dut_c(c3), .dut_f0(f0_3), .dut_f1(f1_3),
      .busy(busy3), .done(done3), .fault_detected(fd3), .fail_mask(mask3),
      .fail_count(cnt3), .first_fail_vec(ffv3), .first_fail_obs(ffo3)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) if (done1) begin : mon1
      exp_t e;
      done_cnt1++;
      if (q1.size() == 0) chk("unexpected_done1", 1, 0);
      else begin
         e = q1.pop_front();
         chk("done1_cycle", cyc, e.cyc);
         chk("mask1", int'(mask1), int'(e.mask));
         chk("count1", int'(cnt1), int'(e.cnt));
         chk("ffv1", int'(ffv1), int'(e.ffv));
         chk("ffo1", int'(ffo1), int'(e.ffo));
         chk("fault1", int'(fd1), int'(e.mask != 0));
         chk("busy1_at_done", int'(busy1), 0);
      end
   end

   always @(negedge clk) if (done3) begin : mon3
      exp_t e;
      done_cnt3++;
      if (q3.size() == 0) chk("unexpected_done3", 1, 0);
      else begin
         e = q3.pop_front();
         chk("done3_cycle", cyc, e.cyc);
         chk("mask3", int'(mask3), int'(e.mask));
         chk("count3", int'(cnt3), int'(e.cnt));
         chk("ffv3", int'(ffv3), int'(e.ffv));
         chk("ffo3", int'(ffo3), int'(e.ffo));
         chk("fault3", int'(fd3), int'(e.mask != 0));
         chk("busy3_at_done", int'(busy3), 0);
      end
   end

   task automatic push1(input logic [7:0] m, input logic [3:0] n, input logic [2:0] v, input logic [1:0] o);
      exp_t e;
      e.mask = m; e.cnt = n; e.ffv = v; e.ffo = o; e.cyc = cyc + 16;
      q1.push_back(e);
   endtask

   task automatic push3(input logic [7:0] m, input logic [3:0] n, input logic [2:0] v, input logic [1:0] o);
      exp_t e;
      e.mask = m; e.cnt = n; e.ffv = v; e.ffo = o; e.cyc = cyc + 32;
      q3.push_back(e);
   endtask

   task automatic go1(input int mode, input logic [7:0] m, input logic [3:0] n, input logic [2:0] v, input logic [1:0] o);
      mode1 = mode;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      push1(m, n, v, o);
      chk("busy1_accept", int'(busy1), 1);
      chk("mask1_cleared", int'(mask1), 0);
   endtask

   task automatic go3(input int mode, input logic [7:0] m, input logic [3:0] n, input logic [2:0] v, input logic [1:0] o);
      mode3 = mode;
      start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      push3(m, n, v, o);
      chk("busy3_accept", int'(busy3), 1);
   endtask

   task automatic wait_done1();
      int i;
      for (i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done1) break;
      end
      if (i == 100) chk("timeout_done1", 0, 1);
   endtask

   task automatic wait_done3();
      int i;
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done3) break;
      end
      if (i == 200) chk("timeout_done3", 0, 1);
   endtask

   task automatic chk_reset1(input string name);
      chk(name, int'({a1, b1, c1, busy1, done1, fd1, mask1, cnt1, ffv1, ffo1}), 0);
   endtask

   initial begin
      int d;
      repeat (2) @(negedge clk);
      chk_reset1("reset1_outputs");
      chk("reset3_outputs", int'({a3, b3, c3, busy3, done3, fd3, mask3, cnt3, ffv3, ffo3}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      // fault-free run with per-edge busy/vector tracking
      go1(0, 8'h00, 4'd0, 3'd0, 2'b00);
      @(negedge clk);
      for (int k = 0; k < 16; k++) begin
         chk("busy1_run", int'(busy1), 1);
         chk("done1_early", int'(done1), 0);
         chk("vec1_run", int'({a1, b1, c1}), k / 2);
         @(negedge clk);
      end
      chk("done1_pulse", int'(done1), 1);
      chk("vec1_done", int'({a1, b1, c1}), 7);
      @(negedge clk);
      chk("done1_one_cycle", int'(done1), 0);
      chk("vec1_hold", int'({a1, b1, c1}), 7);
      chk("busy1_idle", int'(busy1), 0);
      // carry stuck model
      go1(1, 8'h02, 4'd1, 3'd1, 2'b11);
      wait_done1();
      @(negedge clk);
      chk("fault1_held", int'(fd1), 1);
      // sum stuck-at-0 model
      go1(2, 8'h96, 4'd4, 3'd1, 2'b00);
      wait_done1();
      @(negedge clk);
      // start during run is ignored, then reset aborts the run
      go1(0, 8'h00, 4'd0, 3'd0, 2'b00);
      @(negedge clk);
      repeat (6) @(negedge clk);
      chk("vec1_at3", int'({a1, b1, c1}), 3);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("vec1_ignored_start", int'({a1, b1, c1}), 3);
      chk("busy1_ignored_start", int'(busy1), 1);
      @(negedge clk);
      chk("vec1_at4", int'({a1, b1, c1}), 4);
      rst_n = 1'b0;
      #1;
      chk_reset1("reset1_midrun");
      q1.delete();
      d = done_cnt1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("no_done_after_reset", done_cnt1, d);
      chk_reset1("reset1_still_idle");
      go1(2, 8'h96, 4'd4, 3'd1, 2'b00);
      wait_done1();
      @(negedge clk);
      // S=3 run, then start held from the done cycle
      go3(1, 8'h02, 4'd1, 3'd1, 2'b11);
      @(negedge clk);
      for (int k = 0; k < 32; k++) begin
         chk("vec3_run", int'({a3, b3, c3}), k / 4);
         @(negedge clk);
      end
      chk("done3_pulse", int'(done3), 1);
      mode3 = 0;
      start3 = 1'b1;
      @(posedge clk); #1;
      chk("busy3_done_start_ignored", int'(busy3), 0);
      chk("mask3_held", int'(mask3), 8'h02);
      @(posedge clk); #1;
      start3 = 1'b0;
      push3(8'h00, 4'd0, 3'd0, 2'b00);
      chk("busy3_b2b_accept", int'(busy3), 1);
      chk("mask3_cleared", int'(mask3), 0);
      chk("fault3_cleared", int'(fd3), 0);
      wait_done3();
      repeat (3) @(negedge clk);
      chk("q1_drained", q1.size(), 0);
      chk("q3_drained", q3.size(), 0);
      chk("done3_total", done_cnt3, 2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
